reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset.
REQ-003 AluValid  input  1  ALU writeback request.
REQ-004 AluRd  input  5  ALU destination register index.
REQ-005 AluData  input  32  ALU writeback data.
REQ-006 AluReady  output  1  ALU request granted this cycle (combinational).
REQ-007 MemValid  input  1  load-unit writeback request.
REQ-008 MemRd  input  5  load destination register index.
REQ-009 MemData  input  32  load writeback data.
REQ-010 MemReady  output  1  load request granted this cycle (combinational).
REQ-011 IssueValid  input  1  instruction issue attempt.
REQ-012 IssueRs1, IssueRs2, IssueRd  input  5 each  issuing instruction's sources and destination.
REQ-013 Stall  output  1  issue blocked by pending destination (combinational).
REQ-014 RD  output  5  register file write address (registered).
REQ-015 WData  output  32  register file write data (registered).
REQ-016 RegWr  output  1  register file write enable (registered, one-cycle pulse per write).
REQ-017 Busy  output  32  scoreboard; bit n = register n has an outstanding write.

Function
REQ-018 A transfer SHALL occur on a cycle where requester Valid and Ready are both 1; at most one Ready SHALL be 1 per cycle.
REQ-019 Ready SHALL be 0 whenever the corresponding Valid is 0.
REQ-020 Default priority: Mem over Alu when both valid.
REQ-021 Aging: 2-bit counter SHALL increment each cycle AluValid=1 and AluReady=0, saturating at 3; while counter=3, Alu SHALL win over Mem; counter SHALL clear on any Alu transfer or when AluValid=0.
REQ-022 Latency: a transfer in cycle N SHALL drive RD/WData from the granted requester and RegWr=1 in cycle N+1; with no transfer in cycle N, RegWr SHALL be 0 in N+1 and RD/WData SHALL hold.
REQ-023 Transfer with Rd=0: accepted (Ready=1), RegWr SHALL stay 0 in N+1, Busy unaffected.
REQ-024 Back-to-back transfers every cycle SHALL be supported (throughput 1 write/cycle).
REQ-025 Stall = IssueValid AND (Busy[IssueRs1] OR Busy[IssueRs2] OR Busy[IssueRd]), using current-cycle Busy; no bypass from a same-cycle RegWr.
REQ-026 Issue accept (IssueValid=1, Stall=0, IssueRd!=0) SHALL set Busy[IssueRd] next edge.
REQ-027 Busy[RD] SHALL clear on the edge following a cycle with RegWr=1.
REQ-028 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-029 Busy[0] SHALL be constant 0; index 0 SHALL never cause Stall.
REQ-030 Issue and writeback paths SHALL operate independently in the same cycle.

Reset
REQ-031 Reset=0 SHALL asynchronously force RegWr=0, RD=0, WData=0, Busy=0, aging counter=0.
REQ-032 Reset asserted mid-write SHALL drop RegWr the same instant; a granted transfer in that cycle SHALL be discarded.
REQ-033 Ready and Stall SHALL follow their combinational definitions during reset (Busy=0 gives Stall=0).
REQ-034 First write after Reset release SHALL occur no earlier than the second rising edge after release.

Verification
REQ-035 AluValid=1, AluRd=5, AluData=0x1234 alone -> AluReady=1; next cycle RD=5, WData=0x00001234, RegWr=1; following cycle RegWr=0.
REQ-036 Both valid continuously (AluRd=3, MemRd=4) -> Mem granted cycles 0-2, Alu cycle 3, Mem cycle 4; RegWr never gaps.
REQ-037 MemValid=1, MemRd=0, MemData=0xFFFFFFFF -> MemReady=1, RegWr stays 0, Busy=0.
REQ-038 Issue Rd=7 accepted, then IssueRs1=7 -> Stall=1 until one cycle after RegWr with RD=7; then Stall=0.
REQ-039 Same cycle: RegWr for RD=9 and issue accept with IssueRd=9 -> Busy[9]=1 afterward.
REQ-040 Reset pulsed low while RegWr=1, Busy=0x00000080 -> RegWr=0, Busy=0 immediately; outputs remain 0 until next transfer.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: grants one of two writeback sources per cycle
// (Mem first, Alu after aging), registers the write, and keeps a busy scoreboard for issue.
module reg_wb_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        AluValid,
  input  logic [4:0]  AluRd,
  input  logic [31:0] AluData,
  output logic        AluReady,
  input  logic        MemValid,
  input  logic [4:0]  MemRd,
  input  logic [31:0] MemData,
  output logic        MemReady,
  input  logic        IssueValid,
  input  logic [4:0]  IssueRs1,
  input  logic [4:0]  IssueRs2,
  input  logic [4:0]  IssueRd,
  output logic        Stall,
  output logic [4:0]  RD,
  output logic [31:0] WData,
  output logic        RegWr,
  output logic [31:0] Busy
);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_ALU
  } src_e;

  localparam logic [1:0] AGE_MAX = 2'd3;

  src_e        grant;
  logic        xfer;
  logic [4:0]  xfer_rd;
  logic [31:0] xfer_data;

  logic [1:0]  age_q, age_d;
  logic        armed_q;
  logic [31:0] busy_q, busy_d;
  logic [4:0]  rd_q;
  logic [31:0] wdata_q;
  logic        regwr_q;
  logic        issue_accept;

  // Mem wins by default; an Alu request starved for three cycles takes precedence.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant     = SRC_NONE;
    xfer_rd   = 5'd0;
    xfer_data = 32'd0;
    if (AluValid && (!MemValid || age_q == AGE_MAX)) begin
      grant     = SRC_ALU;
      xfer_rd   = AluRd;
      xfer_data = AluData;
    end else if (MemValid) begin
      grant     = SRC_MEM;
      xfer_rd   = MemRd;
      xfer_data = MemData;
    end
  end

  assign AluReady = (grant == SRC_ALU);
  assign MemReady = (grant == SRC_MEM);
  assign xfer     = (grant != SRC_NONE);

  always_comb begin
    age_d = 2'd0;
    if (AluValid && !AluReady) begin
      age_d = (age_q == AGE_MAX) ? AGE_MAX : age_q + 2'd1;
    end
  end

  // Bit 0 of busy_q is never set, so index 0 can never raise Stall.
  assign Stall        = IssueValid && (busy_q[IssueRs1] || busy_q[IssueRs2] || busy_q[IssueRd]);
  assign issue_accept = IssueValid && !Stall && (IssueRd != 5'd0);

  // Clear from the retiring write first, then set from issue, so a collision stays set.
  always_comb begin
    busy_d = busy_q;
    if (regwr_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_accept) begin
      busy_d[IssueRd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // armed_q masks the first edge after reset release so no write lands on it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset along with the rest.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      armed_q <= 1'b0;
      age_q   <= 2'd0;
      busy_q  <= 32'd0;
      rd_q    <= 5'd0;
      wdata_q <= 32'd0;
      regwr_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      age_q   <= age_d;
      busy_q  <= busy_d;
      regwr_q <= armed_q && xfer && (xfer_rd != 5'd0);
      if (armed_q && xfer) begin
        rd_q    <= xfer_rd;
        wdata_q <= xfer_data;
      end
    end
  end

  assign RD    = rd_q;
  assign WData = wdata_q;
  assign RegWr = regwr_q;
  assign Busy  = busy_q;

  a_ready_onehot : assert property (@(posedge Clk) disable iff (!Reset) !(AluReady && MemReady));
  a_ready_valid  : assert property (@(posedge Clk) disable iff (!Reset)
                                    (!AluReady || AluValid) && (!MemReady || MemValid));
  a_wr_nonzero   : assert property (@(posedge Clk) disable iff (!Reset) !RegWr || (RD != 5'd0));

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed vector table, reset corner sequence,
// then randomized traffic compared against a cycle-level reference model.
module tb_reg_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        AluValid, MemValid, IssueValid;
  logic [4:0]  AluRd, MemRd, IssueRs1, IssueRs2, IssueRd;
  logic [31:0] AluData, MemData;
  logic        AluReady, MemReady, Stall, RegWr;
  logic [4:0]  RD;
  logic [31:0] WData, Busy;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  reg_wb_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData), .MemReady(MemReady),
    .IssueValid(IssueValid), .IssueRs1(IssueRs1), .IssueRs2(IssueRs2), .IssueRd(IssueRd),
    .Stall(Stall), .RD(RD), .WData(WData), .RegWr(RegWr), .Busy(Busy)
  );

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        mv;  logic [4:0] mrd; logic [31:0] mdat;
    logic        iv;  logic [4:0] rs1; logic [4:0] rs2; logic [4:0] ird;
    logic        e_ar; logic e_mr; logic e_stall;
    logic        e_wr; logic [4:0] e_rd; logic [31:0] e_wd; logic chk_data;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t row(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
    input logic iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] ird,
    input logic e_ar, input logic e_mr, input logic e_stall,
    input logic e_wr, input logic [4:0] e_rd, input logic [31:0] e_wd, input logic chk_data,
    input logic [31:0] e_busy);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.ird = ird;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_stall = e_stall;
    v.e_wr = e_wr; v.e_rd = e_rd; v.e_wd = e_wd; v.chk_data = chk_data;
    v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
    input logic iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] ird);
    AluValid = av;   AluRd = ard;     AluData = adat;
    MemValid = mv;   MemRd = mrd;     MemData = mdat;
    IssueValid = iv; IssueRs1 = rs1;  IssueRs2 = rs2; IssueRd = ird;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: write pipeline, scoreboard and Alu starvation count.
  logic [31:0] m_busy;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_regwr;
  int          m_wait;
  bit          m_armed;

  task automatic model_reset();
    m_busy = 0; m_rd = 0; m_wd = 0; m_regwr = 0; m_wait = 0; m_armed = 0;
  endtask

  initial begin
    tbl[0]  = row(1,5,32'h1234, 0,0,0,                    0,0,0,0, 1,0,0, 0,0,32'h0,1,32'h0);
    tbl[1]  = row(0,0,0,        0,0,0,                    0,0,0,0, 0,0,0, 1,5,32'h1234,1,32'h0);
    tbl[2]  = row(0,0,0,        0,0,0,                    0,0,0,0, 0,0,0, 0,5,32'h1234,1,32'h0);
    tbl[3]  = row(1,3,32'hA0,   1,4,32'hB0,               0,0,0,0, 0,1,0, 0,5,32'h1234,1,32'h0);
    tbl[4]  = row(1,3,32'hA0,   1,4,32'hB0,               0,0,0,0, 0,1,0, 1,4,32'hB0,1,32'h0);
    tbl[5]  = row(1,3,32'hA0,   1,4,32'hB0,               0,0,0,0, 0,1,0, 1,4,32'hB0,1,32'h0);
    tbl[6]  = row(1,3,32'hA0,   1,4,32'hB0,               0,0,0,0, 1,0,0, 1,4,32'hB0,1,32'h0);
    tbl[7]  = row(1,3,32'hA0,   1,4,32'hB0,               0,0,0,0, 0,1,0, 1,3,32'hA0,1,32'h0);
    tbl[8]  = row(0,0,0,        0,0,0,                    0,0,0,0, 0,0,0, 1,4,32'hB0,1,32'h0);
    tbl[9]  = row(0,0,0,        0,0,0,                    0,0,0,0, 0,0,0, 0,4,32'hB0,1,32'h0);
    tbl[10] = row(0,0,0,        1,0,32'hFFFF_FFFF,        0,0,0,0, 0,1,0, 0,4,32'hB0,1,32'h0);
    tbl[11] = row(1,6,32'h66,   0,0,0,                    0,0,0,0, 1,0,0, 0,0,32'h0,0,32'h0);
    tbl[12] = row(0,0,0,        0,0,0,                    0,0,0,0, 0,0,0, 1,6,32'h66,1,32'h0);
    tbl[13] = row(0,0,0,        0,0,0,                    1,1,2,7, 0,0,0, 0,6,32'h66,1,32'h0);
    tbl[14] = row(0,0,0,        0,0,0,                    1,7,0,0, 0,0,1, 0,6,32'h66,1,32'h80);
    tbl[15] = row(1,7,32'h77,   0,0,0,                    1,7,0,0, 1,0,1, 0,6,32'h66,1,32'h80);
    tbl[16] = row(0,0,0,        0,0,0,                    1,7,0,0, 0,0,1, 1,7,32'h77,1,32'h80);
    tbl[17] = row(0,0,0,        0,0,0,                    1,7,0,0, 0,0,0, 0,7,32'h77,1,32'h0);
    tbl[18] = row(1,9,32'h99,   0,0,0,                    0,0,0,0, 1,0,0, 0,7,32'h77,1,32'h0);
    tbl[19] = row(0,0,0,        0,0,0,                    1,0,0,9, 0,0,0, 1,9,32'h99,1,32'h0);
    tbl[20] = row(0,0,0,        0,0,0,                    0,0,0,0, 0,0,0, 0,9,32'h99,1,32'h200);
    tbl[21] = row(0,0,0,        0,0,0,                    1,0,0,0, 0,0,0, 0,9,32'h99,1,32'h200);
    tbl[22] = row(0,0,0,        0,0,0,                    1,0,9,0, 0,0,1, 0,9,32'h99,1,32'h200);

    // Reset state, with combinational outputs live during reset.
    Reset = 1'b0;
    idle();
    repeat (2) @(negedge Clk);
    check("reset regwr", RegWr, 0);
    check("reset rd", RD, 0);
    check("reset wdata", WData, 0);
    check("reset busy", Busy, 0);
    drive(1, 5, 32'h5, 0, 0, 0, 1, 5, 5, 5);
    #1;
    check("reset alu_ready", AluReady, 1);
    check("reset stall", Stall, 0);
    idle();
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);

    foreach (tbl[i]) begin
      @(negedge Clk);
      drive(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].mv, tbl[i].mrd, tbl[i].mdat,
            tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].ird);
      #1;
      check($sformatf("row%0d alu_ready", i), AluReady, tbl[i].e_ar);
      check($sformatf("row%0d mem_ready", i), MemReady, tbl[i].e_mr);
      check($sformatf("row%0d stall", i), Stall, tbl[i].e_stall);
      check($sformatf("row%0d regwr", i), RegWr, tbl[i].e_wr);
      check($sformatf("row%0d busy", i), Busy, tbl[i].e_busy);
      if (tbl[i].chk_data) begin
        check($sformatf("row%0d rd", i), RD, tbl[i].e_rd);
        check($sformatf("row%0d wdata", i), WData, tbl[i].e_wd);
      end
    end

    // Reset pulsed while a write is on the outputs and a register is busy.
    @(negedge Clk);
    drive(1, 3, 32'h33, 0, 0, 0, 1, 1, 2, 7);
    #1;
    check("mid alu_ready", AluReady, 1);
    check("mid stall", Stall, 0);
    @(negedge Clk);
    idle();
    #1;
    check("mid pre regwr", RegWr, 1);
    check("mid pre busy", Busy, 32'h280);
    Reset = 1'b0;
    #1;
    check("mid regwr drop", RegWr, 0);
    check("mid busy clear", Busy, 0);
    check("mid rd clear", RD, 0);
    check("mid wdata clear", WData, 0);
    drive(1, 5, 32'h55, 0, 0, 0, 1, 7, 0, 0);
    #1;
    check("mid reset alu_ready", AluReady, 1);
    check("mid reset stall", Stall, 0);
    @(negedge Clk);
    check("mid in reset regwr", RegWr, 0);
    Reset = 1'b1;
    @(negedge Clk);
    check("first edge regwr", RegWr, 0);
    check("first edge rd", RD, 0);
    @(negedge Clk);
    check("second edge regwr", RegWr, 1);
    check("second edge rd", RD, 5);
    check("second edge wdata", WData, 32'h55);
    idle();

    // Randomized traffic against the reference model.
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      logic av, mv, iv, alu_g, mem_g, stall_e, xfer;
      logic [4:0]  ard, mrd, rs1, rs2, ird, trd;
      logic [31:0] adat, mdat, tdat, nb;
      av  = ($urandom_range(0, 9) < 7);
      mv  = ($urandom_range(0, 9) < 6);
      iv  = ($urandom_range(0, 9) < 6);
      ard = 5'($urandom_range(0, 7));
      mrd = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 9));
      rs2 = 5'($urandom_range(0, 9));
      ird = 5'($urandom_range(0, 9));
      adat = $urandom;
      mdat = $urandom;
      drive(av, ard, adat, mv, mrd, mdat, iv, rs1, rs2, ird);
      #1;
      alu_g   = av && (!mv || m_wait >= 3);
      mem_g   = mv && !alu_g;
      stall_e = iv && (m_busy[rs1] || m_busy[rs2] || m_busy[ird]);
      check("rnd alu_ready", AluReady, alu_g);
      check("rnd mem_ready", MemReady, mem_g);
      check("rnd stall", Stall, stall_e);
      check("rnd regwr", RegWr, m_regwr);
      check("rnd busy", Busy, m_busy);
      if (m_regwr) begin
        check("rnd rd", RD, m_rd);
        check("rnd wdata", WData, m_wd);
      end
      @(posedge Clk);
      nb = m_busy;
      if (m_regwr) nb[m_rd] = 1'b0;
      if (iv && !stall_e && ird != 0) nb[ird] = 1'b1;
      xfer = alu_g || mem_g;
      trd  = alu_g ? ard : mrd;
      tdat = alu_g ? adat : mdat;
      if (m_armed && xfer) begin
        m_regwr = (trd != 0);
        m_rd    = trd;
        m_wd    = tdat;
      end else begin
        m_regwr = 1'b0;
      end
      m_wait  = (av && !alu_g) ? ((m_wait < 3) ? m_wait + 1 : 3) : 0;
      m_busy  = nb;
      m_armed = 1'b1;
      @(negedge Clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
